// File: rtl/train_fleet_requester_pkg.sv
// Shared definitions for the track-access train side: grant codes, train
// state encoding and fleet size.
package ttcs_pkg;
    localparam int NUM_TRAINS = 4;

    localparam logic [2:0] GRANT_IDLE = 3'd0;
    localparam logic [2:0] GRANT_T1   = 3'd1;
    localparam logic [2:0] GRANT_T2   = 3'd2;
    localparam logic [2:0] GRANT_T3   = 3'd3;
    localparam logic [2:0] GRANT_T4   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } train_state_t;

    function automatic logic [2:0] grant_code(input int idx);
        return 3'(idx + 1);
    endfunction
endpackage

// File: rtl/train_fleet_requester_train_agent.sv
// One train: holds a single transit job, requests the track, counts granted
// occupancy cycles, and reports completion, preemption and misdirected grants.
module train_agent
    import ttcs_pkg::*;
#(
    parameter int IDX   = 0,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic [LEN_W-1:0] len,
    input  logic [2:0]       grant,
    output logic             request,
    output logic             done,
    output logic             busy,
    output logic             preempt,
    output logic             err
);
    localparam logic [2:0] MY_GRANT = grant_code(IDX);

    train_state_t     state, state_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic             request_nxt, done_nxt, granted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            request <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            request <= request_nxt;
            done    <= done_nxt;
        end
    end

    // Job length is datapath; it is only meaningful once a job is accepted.
    always_ff @(posedge clk) begin
        remaining <= remaining_nxt;
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        request_nxt   = request;
        done_nxt      = 1'b0;
        preempt       = 1'b0;
        granted       = (grant == MY_GRANT) && (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt     = ST_WAIT;
                    remaining_nxt = (len == '0) ? LEN_W'(1) : len;
                    request_nxt   = 1'b1;
                end
            end
            ST_WAIT, ST_RUN: begin
                if (granted) begin
                    if (remaining == LEN_W'(1)) begin
                        done_nxt    = 1'b1;
                        request_nxt = 1'b0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        remaining_nxt = remaining - LEN_W'(1);
                        state_nxt     = ST_RUN;
                    end
                end else if (state == ST_RUN) begin
                    // Grant revoked mid-transit: keep the job and the request.
                    preempt   = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    // The arbiter still shows our code during the done cycle; that is legal.
    assign err  = (grant == MY_GRANT) && (state == ST_IDLE) && !done;
endmodule

// File: rtl/train_fleet_requester.sv
// Train-side endpoint of the track-access protocol: four train agents plus
// dispatch decode, completion merge, preemption counting and error capture.
module train_fleet_requester
    import ttcs_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dispatch_valid,
    input  logic [1:0]       dispatch_train,
    input  logic [LEN_W-1:0] dispatch_len,
    output logic             dispatch_ready,
    input  logic [2:0]       grant,
    output logic [3:0]       train_request,
    output logic             train_done,
    output logic [3:0]       train_busy,
    output logic [CNT_W-1:0] preempt_cnt,
    output logic             protocol_err
);
    logic [NUM_TRAINS-1:0] accept, done_vec, preempt_vec, err_vec;

    assign dispatch_ready = !train_busy[dispatch_train];

    for (genvar k = 0; k < NUM_TRAINS; k++) begin : g_train
        assign accept[k] = dispatch_valid && dispatch_ready && (dispatch_train == 2'(k));

        train_agent #(
            .IDX   (k),
            .LEN_W (LEN_W)
        ) u_agent (
            .clk     (clk),
            .reset   (reset),
            .accept  (accept[k]),
            .len     (dispatch_len),
            .grant   (grant),
            .request (train_request[k]),
            .done    (done_vec[k]),
            .busy    (train_busy[k]),
            .preempt (preempt_vec[k]),
            .err     (err_vec[k])
        );
    end

    // Only one train can hold the grant, so at most one done/preempt per cycle.
    assign train_done = |done_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preempt_cnt  <= '0;
            protocol_err <= 1'b0;
        end else begin
            if ((|preempt_vec) && (preempt_cnt != '1))
                preempt_cnt <= preempt_cnt + CNT_W'(1);
            if ((grant > GRANT_T4) || (|err_vec))
                protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_train_fleet_requester.sv
// Directed bench for train_fleet_requester: a per-cycle vector table plus
// hand sequences for async reset, illegal grant codes and counter saturation.
module tb_train_fleet_requester;
    logic       clk = 1'b0;
    logic       reset;
    logic       dispatch_valid;
    logic [1:0] dispatch_train;
    logic [7:0] dispatch_len;
    logic       dispatch_ready;
    logic [2:0] grant;
    logic [3:0] train_request;
    logic       train_done;
    logic [3:0] train_busy;
    logic [7:0] preempt_cnt;
    logic       protocol_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    train_fleet_requester #(.LEN_W(8), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .dispatch_valid (dispatch_valid),
        .dispatch_train (dispatch_train),
        .dispatch_len   (dispatch_len),
        .dispatch_ready (dispatch_ready),
        .grant          (grant),
        .train_request  (train_request),
        .train_done     (train_done),
        .train_busy     (train_busy),
        .preempt_cnt    (preempt_cnt),
        .protocol_err   (protocol_err)
    );

    typedef struct {
        logic       dv;
        logic [1:0] dt;
        logic [7:0] dl;
        logic [2:0] g;
        logic [3:0] req;   // expected request and busy vectors
        logic       done;
        logic [7:0] cnt;
        logic       err;
        logic       rdy;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic dv, input logic [1:0] dt, input logic [7:0] dl,
                                input logic [2:0] g, input logic [3:0] req, input logic done,
                                input logic [7:0] cnt, input logic err, input logic rdy);
        vec_t v;
        v.dv = dv; v.dt = dt; v.dl = dl; v.g = g;
        v.req = req; v.done = done; v.cnt = cnt; v.err = err; v.rdy = rdy;
        return v;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic dv, input logic [1:0] dt, input logic [7:0] dl,
                         input logic [2:0] g);
        dispatch_valid = dv;
        dispatch_train = dt;
        dispatch_len   = dl;
        grant          = g;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 8'd0, 3'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one cycle's inputs after the edge, then let it clock.
    task automatic step(input logic dv, input logic [1:0] dt, input logic [7:0] dl,
                        input logic [2:0] g);
        @(posedge clk);
        #1;
        drive(dv, dt, dl, g);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'd0, 8'd0, 3'd0);

        //             dv  dt  dl  g   req    dn cnt err rdy
        tbl[0]  = mk(1, 0, 3, 0, 4'b0000, 0, 0, 0, 1);
        tbl[1]  = mk(0, 0, 0, 1, 4'b0001, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 4'b0001, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 4'b0001, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 4'b0000, 1, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
        tbl[6]  = mk(1, 2, 4, 0, 4'b0000, 0, 0, 0, 1);
        tbl[7]  = mk(0, 2, 0, 3, 4'b0100, 0, 0, 0, 0);
        tbl[8]  = mk(0, 2, 0, 3, 4'b0100, 0, 0, 0, 0);
        tbl[9]  = mk(0, 2, 0, 0, 4'b0100, 0, 0, 0, 0);
        tbl[10] = mk(0, 2, 0, 0, 4'b0100, 0, 1, 0, 0);
        tbl[11] = mk(0, 2, 0, 0, 4'b0100, 0, 1, 0, 0);
        tbl[12] = mk(0, 2, 0, 3, 4'b0100, 0, 1, 0, 0);
        tbl[13] = mk(0, 2, 0, 3, 4'b0100, 0, 1, 0, 0);
        tbl[14] = mk(0, 2, 0, 3, 4'b0000, 1, 1, 0, 1);
        tbl[15] = mk(0, 2, 0, 0, 4'b0000, 0, 1, 0, 1);
        tbl[16] = mk(1, 1, 1, 0, 4'b0000, 0, 1, 0, 1);
        tbl[17] = mk(1, 3, 1, 0, 4'b0010, 0, 1, 0, 1);
        tbl[18] = mk(0, 1, 0, 2, 4'b1010, 0, 1, 0, 0);
        tbl[19] = mk(0, 1, 0, 4, 4'b1000, 1, 1, 0, 1);
        tbl[20] = mk(0, 3, 0, 0, 4'b0000, 1, 1, 0, 1);
        tbl[21] = mk(0, 0, 0, 0, 4'b0000, 0, 1, 0, 1);
        tbl[22] = mk(1, 0, 0, 0, 4'b0000, 0, 1, 0, 1);
        tbl[23] = mk(0, 0, 0, 1, 4'b0001, 0, 1, 0, 0);
        tbl[24] = mk(0, 0, 0, 1, 4'b0000, 1, 1, 0, 1);
        tbl[25] = mk(0, 0, 0, 0, 4'b0000, 0, 1, 0, 1);
        tbl[26] = mk(0, 1, 0, 2, 4'b0000, 0, 1, 0, 1);
        tbl[27] = mk(0, 1, 0, 0, 4'b0000, 0, 1, 1, 1);
        tbl[28] = mk(1, 3, 2, 0, 4'b0000, 0, 1, 1, 1);
        tbl[29] = mk(0, 3, 0, 4, 4'b1000, 0, 1, 1, 0);
        tbl[30] = mk(0, 3, 0, 4, 4'b1000, 0, 1, 1, 0);
        tbl[31] = mk(0, 3, 0, 0, 4'b0000, 1, 1, 1, 1);

        do_reset();
        check("reset_request", train_request, 0);
        check("reset_done",    train_done,    0);
        check("reset_busy",    train_busy,    0);
        check("reset_cnt",     preempt_cnt,   0);
        check("reset_err",     protocol_err,  0);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].dv, tbl[i].dt, tbl[i].dl, tbl[i].g);
            @(negedge clk);
            check($sformatf("v%0d_request", i), train_request, tbl[i].req);
            check($sformatf("v%0d_busy", i),    train_busy,    tbl[i].req);
            check($sformatf("v%0d_done", i),    train_done,    tbl[i].done);
            check($sformatf("v%0d_cnt", i),     preempt_cnt,   tbl[i].cnt);
            check($sformatf("v%0d_err", i),     protocol_err,  tbl[i].err);
            check($sformatf("v%0d_ready", i),   dispatch_ready, tbl[i].rdy);
        end

        // Async reset while train 0 is in RUN with 5 cycles left.
        do_reset();
        step(1'b1, 2'd0, 8'd7, 3'd0);
        step(1'b0, 2'd0, 8'd0, 3'd1);
        step(1'b0, 2'd0, 8'd0, 3'd1);
        @(posedge clk);
        #3;
        check("run_before_reset", train_busy, 4'b0001);
        reset = 1'b1;
        #1;
        check("async_request", train_request, 0);
        check("async_busy",    train_busy,    0);
        check("async_done",    train_done,    0);
        check("async_cnt",     preempt_cnt,   0);
        check("async_err",     protocol_err,  0);
        drive(1'b0, 2'd0, 8'd0, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_done",  train_done,     0);
            check("post_reset_ready", dispatch_ready, 1);
        end

        // Grant code 6 is illegal; the fleet keeps working afterwards.
        do_reset();
        step(1'b0, 2'd0, 8'd0, 3'd6);
        @(negedge clk);
        check("g6_err_pre", protocol_err, 0);
        step(1'b1, 2'd0, 8'd1, 3'd0);
        @(negedge clk);
        check("g6_err_set", protocol_err, 1);
        check("g6_no_req",  train_request, 0);
        step(1'b0, 2'd0, 8'd0, 3'd1);
        @(negedge clk);
        check("g6_req", train_request, 4'b0001);
        step(1'b0, 2'd0, 8'd0, 3'd0);
        @(negedge clk);
        check("g6_done",     train_done,   1);
        check("g6_err_held", protocol_err, 1);

        // Preemption counter saturation: 300 revocations across trains 0 and 1.
        do_reset();
        step(1'b1, 2'd0, 8'd255, 3'd0);
        step(1'b1, 2'd1, 8'd255, 3'd0);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 2'd0, 8'd0, (i < 200) ? 3'd1 : 3'd2);
            step(1'b0, 2'd0, 8'd0, 3'd0);
            if (i == 99) begin
                @(negedge clk);
                check("sat_cnt_mid", preempt_cnt, 99);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("sat_cnt",  preempt_cnt,   8'hff);
        check("sat_busy", train_busy,    4'b0011);
        check("sat_err",  protocol_err,  0);
        check("sat_done", train_done,    0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/train_fleet_requester.md
# train_fleet_requester

Train-side endpoint of the track-access protocol: models four trains, each holding one pending transit job, and drives `train_request[3:0]` and `train_done` toward the track arbiter while consuming its 3-bit `grant` code. The block counts granted occupancy cycles per train and pulses `train_done` when a transit completes. It resumes preempted transits when the arbiter revokes a grant on timeout, and flags illegal grant activity. It sits between the dispatch/scheduling logic and the track arbiter.

## Interface
- `LEN_W`, 8: width of the transit length (occupancy cycles).
- `CNT_W`, 8: width of the saturating preemption counter.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `dispatch_valid` in 1: a transit job is offered.
- `dispatch_train` in 2: target train index, 0..3.
- `dispatch_len` in LEN_W: required occupancy cycles; 0 is treated as 1.
- `dispatch_ready` out 1: combinational; high when the train selected by `dispatch_train` is IDLE.
- `grant` in 3: arbiter grant code; 0 = none, k+1 = train k, 5..7 illegal.
- `train_request` out 4: registered per-train request level.
- `train_done` out 1: registered one-cycle completion pulse.
- `train_busy` out 4: train is in WAIT or RUN.
- `preempt_cnt` out CNT_W: saturating count of revoked grants.
- `protocol_err` out 1: sticky error flag.

## Operation
- Per-train FSM with three states:
  - IDLE: no job held.
  - WAIT: request asserted, not granted.
  - RUN: granted in the previous cycle.
- Dispatch:
  - A job is accepted on `dispatch_valid && dispatch_ready`.
  - On acceptance, `remaining <= max(dispatch_len, 1)` and the train goes IDLE→WAIT.
  - `train_request[k]` rises on the same edge.
- Occupancy cycle for train k: `grant == k+1` while train k is in WAIT or RUN.
  - If `remaining == 1`: set done_k, clear `train_request[k]`, go to IDLE.
  - Otherwise: decrement `remaining` and go to RUN.
- Preemption:
  - Condition: train k is in RUN and `grant != k+1`, with no done pending.
  - Train k goes to WAIT; `remaining` is kept; the request stays high.
  - `preempt_cnt` increments and saturates at all-ones.
- `train_done` is the OR of the per-train done pulses; only one train can be granted at a time, so at most one pulse is active.
- `protocol_err` is set and held until reset when either:
  - `grant` is 5..7, or
  - `grant == k+1` while train k is IDLE, excluding the cycle in which train k's done is high.
  - Illegal grants otherwise behave as "no grant".
- Simultaneous dispatch to a train and that train's completion is not possible: `dispatch_ready` is low until the train is IDLE.
- Dispatch to train k in the same cycle `train_done` is high for train j is allowed.

## Timing
- Reset values: `train_request = 0`, `train_done = 0`, `train_busy = 0`, `preempt_cnt = 0`, `protocol_err = 0`; all trains IDLE. Reset mid-transit discards all jobs with no done pulse.
- Dispatch to request latency: 1 cycle.
- A train with length L emits `train_done` in the cycle after its L-th occupancy cycle.
  - In that cycle `train_request[k]` is already 0 and `grant` still reads k+1.
  - That cycle is not an occupancy cycle.
- Because the request is cleared together with the done pulse, the arbiter sees the updated request vector when it reselects.
- Occupancy cycles need not be contiguous; counting pauses while the grant is revoked.

## Structure
- Shared package `ttcs_pkg`:
  - grant code constants `GRANT_IDLE = 0`, `GRANT_T1..GRANT_T4 = 1..4`;
  - train state enum (IDLE, WAIT, RUN);
  - `NUM_TRAINS = 4`.
- Sub-module `train_agent`, instantiated 4× with its index as a parameter, contains:
  - FSM, `remaining` counter, request, done and preempt-event outputs, per-train error output.
- Top level contains:
  - dispatch decode and `dispatch_ready` mux;
  - done OR;
  - preemption counter (sum of per-train events; at most one per cycle);
  - error aggregation.

## Test plan
- Dispatch train 0 with len 3; hold grant=1 from cycle 2 → `train_request` = 0001 from cycle 1; `train_done` high for exactly one cycle after 3 granted cycles; `train_request` = 0000 in that cycle.
- Dispatch train 2 with len 4; grant=3 for 2 cycles, then 0 for 3 cycles, then 3 again → `preempt_cnt` = 1; request stays high; done after 2 further granted cycles.
- Dispatch trains 1 and 3 with len 1; grant=2, then on done switch grant to 4 → two done pulses one cycle apart in sequence; both requests clear.
- Dispatch len 0 to train 0 with grant=1 → done after 1 granted cycle.
- grant=6, and separately grant=2 while train 1 is IDLE → `protocol_err` set and held; other trains unaffected.
- Assert reset during RUN with remaining 5 → all outputs 0 immediately; no done pulse; `dispatch_ready` high after reset release.
